led_scan_scheduler: RTL
=======================

Name: led_scan_scheduler

Overview:
Time-multiplexed refresh scheduler for the single 10-bit LEDout bus that drives the 8x16 game matrix. Several drawing sources (bar 1, bar 2, ball, score/effects) each submit a small list of pixels. The block visits the sources in fixed order, snapshots each one's pixel list, and shows every enabled pixel for a programmable dwell. It inserts a blanking gap after each source and signals frame boundaries. It replaces the ad-hoc colour-counter case decode inside the game top level.

Parameters:
NUM_SRC, 4, number of drawing sources (2..8)
MAX_PIX, 4, pixel slots per source (1..8)
PRESCALER_VALUE, 22'd2000, tick period minus 1 in CLK cycles
DWELL_TICKS, 4, ticks each pixel is held (1..255)
BLANK_TICKS, 1, ticks LEDout is forced to 0 after each source (0..255; 0 = no gap)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
SRC_REQ  in  NUM_SRC  source i has pixels to draw
SRC_PIX  in  NUM_SRC*MAX_PIX*10  pixel word k of source i at bits [(i*MAX_PIX+k)*10 +: 10]; word = {colour[2:0], y[3:0], x[2:0]}
SRC_MASK  in  NUM_SRC*MAX_PIX  enable for pixel word k of source i at bit i*MAX_PIX+k
LEDout  out  10  pixel word presently driven to the matrix; 0 = dark
SRC_ACK  out  NUM_SRC  1-clk pulse when source i's list is snapshotted
CUR_SRC  out  3  index of source being scanned
FRAME_START  out  1  1-clk pulse when a full pass completes and index returns to 0
BUSY  out  1  high in SHOW or BLANK

Behaviour:
- Interface: one clock (CLK); reset RST is asynchronous and active-high.
- Reset values: LEDout=0, SRC_ACK=0, CUR_SRC=0, FRAME_START=0, BUSY=0. Prescaler=0. State=LOAD. Snapshot registers=0.
- Prescaler:
  - Counts 0..PRESCALER_VALUE and wraps.
  - tick=1 in the cycle the count equals PRESCALER_VALUE.
- State LOAD (1 clk, no tick needed), source i=CUR_SRC:
  - If SRC_REQ[i]=1 and mask slice !=0: latch the MAX_PIX pixel words and mask, pulse SRC_ACK[i], set pix index p to the lowest set mask bit, go SHOW.
  - Otherwise skip: go ADVANCE with no ACK.
- State SHOW:
  - LEDout = snapshot word p.
  - On each tick, increment the dwell counter.
  - When the counter reaches DWELL_TICKS: p = next higher set mask bit and the counter clears.
  - If no higher bit is set, go BLANK, or go ADVANCE if BLANK_TICKS=0.
  - LEDout updates on the clock edge after the terminating tick.
- State BLANK:
  - LEDout=0.
  - After BLANK_TICKS ticks, go ADVANCE.
- State ADVANCE (1 clk):
  - If CUR_SRC=NUM_SRC-1: CUR_SRC=0 and pulse FRAME_START.
  - Else CUR_SRC+1.
  - Then LOAD.
- Unmasked pixel slots are never shown and consume no time.
- LEDout is the word verbatim, colour 0 included.
- Snapshot rule: SRC_PIX, SRC_MASK and SRC_REQ changes after the LOAD cycle have no effect until that source's next visit. No tearing within a source.
- All sources idle: LOAD/ADVANCE alternate, LEDout stays 0, and FRAME_START pulses every 2*NUM_SRC clocks.
- A tick landing in LOAD or ADVANCE is not counted. Dwell and blank count only ticks seen in SHOW/BLANK.
- Counters are 8 bits wide and compare for equality only. No wrap is possible within parameter limits.
- Reset asserted mid-SHOW: LEDout goes to 0 immediately (asynchronously). On release, scanning restarts at source 0 from LOAD.
- SRC_ACK and FRAME_START are never high for more than one clock. SRC_ACK is one-hot or zero.

Test Plan:
- Bench parameters for all cases: PRESCALER_VALUE=1, NUM_SRC=4, MAX_PIX=4, DWELL_TICKS=2, BLANK_TICKS=1.
- Reset then release, all SRC_REQ=0 -> LEDout=0 always. FRAME_START pulses every 8 clks. SRC_ACK stays 0.
- Only source 0 requests, mask=4'b0101, pixels 0x268 (slot 0) and 0x10A (slot 2) -> SRC_ACK[0] pulses once per frame. LEDout shows 0x268 for 2 ticks, then 0x10A for 2 ticks, then 0 for 1 tick. Slots 1 and 3 never appear.
- Sources 1 and 3 request with one pixel each (0x131, 0x3FF) -> per frame order is 0x131, blank, 0x3FF, blank. CUR_SRC steps 0,1,2,3,0. FRAME_START fires after source 3's blank.
- Change source 1's pixel from 0x131 to 0x139 one clk after SRC_ACK[1] -> the current visit still shows 0x131. The next frame shows 0x139.
- Assert RST mid-SHOW while LEDout=0x3FF -> LEDout=0 in the same cycle. After release, the first SRC_ACK is for the lowest-index requesting source.
- BLANK_TICKS=0, source 2 only, mask=4'b1111 -> four pixels shown back to back with no zero gap. ADVANCE follows directly after the last dwell.

Source files
------------

// File: rtl/led_scan_scheduler.sv
// LED matrix refresh scheduler: visits each drawing source in turn, snapshots
// its pixel list, holds every enabled pixel on LEDout for a fixed number of
// prescaler ticks, blanks between sources and flags the start of each frame.
module led_scan_scheduler #(
    parameter int          NUM_SRC         = 4,
    parameter int          MAX_PIX         = 4,
    parameter logic [21:0] PRESCALER_VALUE = 22'd2000,
    parameter int          DWELL_TICKS     = 4,
    parameter int          BLANK_TICKS     = 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_SRC-1:0]          SRC_REQ,
    input  logic [NUM_SRC*MAX_PIX*10-1:0] SRC_PIX,
    input  logic [NUM_SRC*MAX_PIX-1:0]  SRC_MASK,
    output logic [9:0]                  LEDout,
    output logic [NUM_SRC-1:0]          SRC_ACK,
    output logic [2:0]                  CUR_SRC,
    output logic                        FRAME_START,
    output logic                        BUSY
);

    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_SHOW    = 2'd1;
    localparam logic [1:0] ST_BLANK   = 2'd2;
    localparam logic [1:0] ST_ADVANCE = 2'd3;

    localparam logic [7:0] DWELL_LAST = 8'(DWELL_TICKS);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_TICKS);
    localparam logic [2:0] LAST_SRC   = 3'(NUM_SRC - 1);

    logic [21:0]             presc_q, presc_d;
    logic                    tick;
    logic [1:0]              state_q, state_d;
    logic [2:0]              src_q, src_d;
    logic [2:0]              pix_q, pix_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [MAX_PIX*10-1:0]   snap_pix_q, snap_pix_d;
    logic [MAX_PIX-1:0]      snap_mask_q, snap_mask_d;
    logic [NUM_SRC-1:0]      ack_q, ack_d;
    logic                    frame_q, frame_d;

    logic                    cur_req;
    logic [MAX_PIX-1:0]      cur_mask;
    logic [MAX_PIX*10-1:0]   cur_words;
    logic [2:0]              first_idx;
    logic                    first_found;
    logic [2:0]              next_idx;
    logic                    next_found;
    logic [9:0]              shown_word;

    // Free-running tick generator, independent of the scan state
    assign tick    = (presc_q == PRESCALER_VALUE);
    assign presc_d = tick ? '0 : presc_q + 22'd1;

    // Select the request, mask and pixel words of the source being visited
    always_comb begin
        cur_req   = 1'b0;
        cur_mask  = '0;
        cur_words = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (src_q == 3'(i)) begin
                cur_req   = SRC_REQ[i];
                cur_mask  = SRC_MASK[i*MAX_PIX +: MAX_PIX];
                cur_words = SRC_PIX[i*MAX_PIX*10 +: MAX_PIX*10];
            end
        end
    end

    // Lowest enabled slot of the live mask and next enabled slot above pix_q
    // in the snapshot; masked-off slots are skipped without costing time
    always_comb begin
        first_idx   = '0;
        first_found = 1'b0;
        next_idx    = '0;
        next_found  = 1'b0;
        for (int unsigned k = 0; k < MAX_PIX; k++) begin
            if (cur_mask[k] && !first_found) begin
                first_idx   = 3'(k);
                first_found = 1'b1;
            end
            if (snap_mask_q[k] && (3'(k) > pix_q) && !next_found) begin
                next_idx   = 3'(k);
                next_found = 1'b1;
            end
        end
    end

    // Word currently selected from the snapshot
    always_comb begin
        shown_word = '0;
        for (int unsigned k = 0; k < MAX_PIX; k++) begin
            if (pix_q == 3'(k)) begin
                shown_word = snap_pix_q[k*10 +: 10];
            end
        end
    end

    // Scan sequencing: LOAD -> SHOW -> BLANK -> ADVANCE -> LOAD
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        pix_d       = pix_q;
        cnt_d       = cnt_q;
        snap_pix_d  = snap_pix_q;
        snap_mask_d = snap_mask_q;
        ack_d       = '0;
        frame_d     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (cur_req && first_found) begin
                    snap_pix_d  = cur_words;
                    snap_mask_d = cur_mask;
                    ack_d       = {{(NUM_SRC-1){1'b0}}, 1'b1} << src_q;
                    pix_d       = first_idx;
                    cnt_d       = '0;
                    state_d     = ST_SHOW;
                end else begin
                    state_d = ST_ADVANCE;
                end
            end
            ST_SHOW: begin
                if (tick) begin
                    if (cnt_q + 8'd1 == DWELL_LAST) begin
                        cnt_d = '0;
                        if (next_found) begin
                            pix_d = next_idx;
                        end else if (BLANK_TICKS == 0) begin
                            state_d = ST_ADVANCE;
                        end else begin
                            state_d = ST_BLANK;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_BLANK: begin
                if (tick) begin
                    if (cnt_q + 8'd1 == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_ADVANCE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                if (src_q == LAST_SRC) begin
                    src_d   = '0;
                    frame_d = 1'b1;
                end else begin
                    src_d = src_q + 3'd1;
                end
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and snapshot registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc_q     <= '0;
            state_q     <= ST_LOAD;
            src_q       <= '0;
            pix_q       <= '0;
            cnt_q       <= '0;
            snap_pix_q  <= '0;
            snap_mask_q <= '0;
            ack_q       <= '0;
            frame_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            state_q     <= state_d;
            src_q       <= src_d;
            pix_q       <= pix_d;
            cnt_q       <= cnt_d;
            snap_pix_q  <= snap_pix_d;
            snap_mask_q <= snap_mask_d;
            ack_q       <= ack_d;
            frame_q     <= frame_d;
        end
    end

    // LEDout follows the state register, so reset darkens it immediately
    assign LEDout      = (state_q == ST_SHOW) ? shown_word : '0;
    assign SRC_ACK     = ack_q;
    assign CUR_SRC     = src_q;
    assign FRAME_START = frame_q;
    assign BUSY        = (state_q == ST_SHOW) || (state_q == ST_BLANK);

endmodule
